rat_intr_ctrl: RTL



---
 rtl/rat_io_pkg.sv | 18 +
 rtl/irq_edge_sync.sv | 30 +++
 rtl/rat_intr_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rat_io_pkg.sv
// RAT wrapper I/O map: port IDs shared by the wrapper muxes
// and the interrupt controller, plus the controller FSM states.
package rat_io_pkg;

  localparam logic [7:0] SWITCHES_ID = 8'h20;
  localparam logic [7:0] LEDS_ID     = 8'h40;
  localparam logic [7:0] MASK_ID     = 8'h60;
  localparam logic [7:0] STATUS_ID   = 8'h61;
  localparam logic [7:0] VECTOR_ID   = 8'h62;
  localparam logic [7:0] CLEAR_ID    = 8'h63;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } intr_state_t;

endpackage

// File: rtl/irq_edge_sync.sv
// Per-bit 2-FF synchroniser, history flop and rising-edge pulse.
// Ports: CLK, RESET (async high), IRQ raw in, RISE one-cycle pulses.
module irq_edge_sync #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] IRQ,
  output logic [W-1:0] RISE
);

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  logic [W-1:0] hist;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= IRQ;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign RISE = sync2 & ~hist;

endmodule

// File: rtl/rat_intr_ctrl.sv
// Port-mapped interrupt controller sharing the RAT MCU INTV input.
// Ports: CLK, RESET (async high), IRQ sources, PORT_ID/OUT_PORT/IO_STRB
// write bus, RD_DATA/RD_HIT to the input-port mux, INTV to the MCU.
module rat_intr_ctrl
  import rat_io_pkg::intr_state_t;
  import rat_io_pkg::IDLE;
  import rat_io_pkg::ASSERT;
  import rat_io_pkg::HOLDOFF;
#(
  parameter int         N_SRC       = 4,
  parameter logic [7:0] MASK_ID     = rat_io_pkg::MASK_ID,
  parameter logic [7:0] STATUS_ID   = rat_io_pkg::STATUS_ID,
  parameter logic [7:0] VECTOR_ID   = rat_io_pkg::VECTOR_ID,
  parameter logic [7:0] CLEAR_ID    = rat_io_pkg::CLEAR_ID,
  parameter int         HOLDOFF_CYC = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic [7:0]       RD_DATA,
  output logic             RD_HIT,
  output logic             INTV
);

  localparam logic [7:0] CNT_LOAD = 8'(HOLDOFF_CYC - 1);

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] act;
  logic [N_SRC-1:0] clr_bits;
  logic             wr_mask;
  logic             wr_clr;
  logic             req;
  logic [2:0]       vec_idx;
  logic [7:0]       cnt;
  logic [7:0]       cnt_nxt;
  intr_state_t      state;
  intr_state_t      state_nxt;
  logic             unused_out;

  assign unused_out = ^OUT_PORT;

  irq_edge_sync #(
    .W(N_SRC)
  ) u_sync (
    .CLK  (CLK),
    .RESET(RESET),
    .IRQ  (IRQ),
    .RISE (rise)
  );

  assign wr_mask  = IO_STRB && (PORT_ID == MASK_ID);
  assign wr_clr   = IO_STRB && (PORT_ID == CLEAR_ID);
  assign clr_bits = wr_clr ? OUT_PORT[N_SRC-1:0] : '0;
  assign act      = pend & mask;
  assign req      = |act;

  // A new edge on the same cycle as its clear keeps the bit set.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend <= '0;
      mask <= '0;
    end else begin
      pend <= (pend & ~clr_bits) | rise;
      if (wr_mask)
        mask <= OUT_PORT[N_SRC-1:0];
    end
  end

  always_comb begin
    vec_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (act[i])
        vec_idx = 3'(i);
  end

  always_comb begin
    RD_DATA = '0;
    RD_HIT  = 1'b0;
    unique case (1'b1)
      (PORT_ID == MASK_ID): begin
        RD_DATA[N_SRC-1:0] = mask;
        RD_HIT = 1'b1;
      end
      (PORT_ID == STATUS_ID): begin
        RD_DATA[N_SRC-1:0] = pend;
        RD_HIT = 1'b1;
      end
      (PORT_ID == VECTOR_ID): begin
        if (req)
          RD_DATA = {1'b1, 4'b0, vec_idx};
        RD_HIT = 1'b1;
      end
      default: ;
    endcase
  end

  // The acknowledge only starts a holdoff while INTV is up;
  // later clears during holdoff leave the counter alone.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE:
        if (req)
          state_nxt = ASSERT;
      ASSERT:
        if (wr_clr) begin
          state_nxt = HOLDOFF;
          cnt_nxt   = CNT_LOAD;
        end else if (!req) begin
          state_nxt = IDLE;
        end
      HOLDOFF:
        if (cnt == 8'd0)
          state_nxt = IDLE;
        else
          cnt_nxt = cnt - 8'd1;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
      INTV  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      INTV  <= (state_nxt == ASSERT);
    end
  end

endmodule
